// File: rtl/pwm_audio_pkg.sv
// Shared types and helpers for the PWM volume ramp: FSM states, level width
// and the level-to-fill-count mapping used by the per-channel mapper.
package pwm_audio_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_t;

  function automatic int lvl_width(input int out_w);
    return $clog2(2 * out_w);
  endfunction

  // Number of low bits that carry the PWM bit in the low (hi_sel=0) or high word.
  function automatic int fill_count(input int level, input int out_w, input bit hi_sel);
    int n;
    n = 0;
    if (!hi_sel) begin
      if (level == 0)
        n = 0;
      else if (level + 1 >= out_w)
        n = out_w;
      else
        n = level + 1;
    end else begin
      if (level <= out_w)
        n = 0;
      else
        n = level - out_w + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/pwm_volume_ramp_mapper.sv
// Combinational mapper: one volume level plus one PWM bit to low/high drive words.
import pwm_audio_pkg::*;

module pwm_level_mapper #(
  parameter int OUT_W = 8,
  parameter int LVL_W = 4
) (
  input  logic [LVL_W-1:0] level,
  input  logic             bit_in,
  output logic [OUT_W-1:0] lo,
  output logic [OUT_W-1:0] hi
);

  int n_lo;
  int n_hi;

  always_comb begin
    n_lo = fill_count(int'(level), OUT_W, 1'b0);
    n_hi = fill_count(int'(level), OUT_W, 1'b1);
    lo   = '0;
    hi   = '0;
    for (int i = 0; i < OUT_W; i++) begin
      lo[i] = bit_in && (i < n_lo);
      hi[i] = bit_in && (i < n_hi);
    end
  end

endmodule

// File: rtl/pwm_volume_ramp.sv
// Shared-volume PWM-to-audio drive with a rate-limited level ramp.
// Optional macro PWM_VOL_MUTE_EN adds a mute input that ramps the level to 0.
import pwm_audio_pkg::*;

module pwm_volume_ramp #(
  parameter int CH       = 2,
  parameter int OUT_W    = 8,
  parameter int RAMP_DIV = 256,
  localparam int LVL_W   = lvl_width(OUT_W)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LVL_W-1:0]    vol_target,
  input  logic                vol_load,
  input  logic [CH-1:0]       pwm_in,
`ifdef PWM_VOL_MUTE_EN
  input  logic                mute,
`endif
  output logic [CH*OUT_W-1:0] audio_lo,
  output logic [CH*OUT_W-1:0] audio_hi,
  output logic                ramp_busy,
  output logic [LVL_W-1:0]    vol_cur
);

  localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);

  state_t              state, state_nxt;
  logic [LVL_W-1:0]    tgt;
  logic [LVL_W-1:0]    cur, cur_nxt;
  logic [DIV_W-1:0]    div, div_nxt;
  logic [LVL_W-1:0]    eff;
  logic [CH*OUT_W-1:0] map_lo, map_hi;
  logic [CH*OUT_W-1:0] lo_p1, hi_p1;

`ifdef PWM_VOL_MUTE_EN
  assign eff = mute ? '0 : tgt;
`else
  assign eff = tgt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      tgt   <= '0;
      cur   <= '0;
      div   <= '0;
      state <= IDLE;
    end else begin
      if (vol_load)
        tgt <= vol_target;
      cur   <= cur_nxt;
      div   <= div_nxt;
      state <= state_nxt;
    end
  end

  // Retargeting never touches div, so a new load lands on the running step grid.
  always_comb begin
    state_nxt = state;
    cur_nxt   = cur;
    div_nxt   = div;
    case (state)
      IDLE: begin
        if (eff != cur) begin
          state_nxt = RAMP;
          div_nxt   = '0;
        end
      end
      RAMP: begin
        if (div == DIV_LAST) begin
          div_nxt = '0;
          if (eff == cur) begin
            state_nxt = IDLE;
          end else begin
            cur_nxt = (eff > cur) ? cur + LVL_W'(1) : cur - LVL_W'(1);
            if ((eff > cur) ? (cur + LVL_W'(1) == eff) : (cur - LVL_W'(1) == eff))
              state_nxt = IDLE;
          end
        end else begin
          div_nxt = div + DIV_W'(1);
        end
      end
    endcase
  end

  assign ramp_busy = (state == RAMP);
  assign vol_cur   = cur;

  for (genvar k = 0; k < CH; k++) begin : g_ch
    pwm_level_mapper #(
      .OUT_W(OUT_W),
      .LVL_W(LVL_W)
    ) u_map (
      .level (cur),
      .bit_in(pwm_in[k]),
      .lo    (map_lo[k*OUT_W +: OUT_W]),
      .hi    (map_hi[k*OUT_W +: OUT_W])
    );
  end

  // Stage p1: mapped words
  always_ff @(posedge clk) begin
    if (rst) begin
      lo_p1 <= '0;
      hi_p1 <= '0;
    end else begin
      lo_p1 <= map_lo;
      hi_p1 <= map_hi;
    end
  end

  // Stage p2: output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      audio_lo <= '0;
      audio_hi <= '0;
    end else begin
      audio_lo <= lo_p1;
      audio_hi <= hi_p1;
    end
  end

endmodule

// File: tb/tb_pwm_volume_ramp.sv
// Directed bench for pwm_volume_ramp (CH=2, OUT_W=8, RAMP_DIV=4).
module tb_pwm_volume_ramp;

  localparam int CH = 2;
  localparam int OUT_W = 8;
  localparam int RAMP_DIV = 4;
  localparam int LVL_W = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [LVL_W-1:0]    vol_target;
  logic                vol_load;
  logic [CH-1:0]       pwm_in;
`ifdef PWM_VOL_MUTE_EN
  logic                mute;
`endif
  logic [CH*OUT_W-1:0] audio_lo;
  logic [CH*OUT_W-1:0] audio_hi;
  logic                ramp_busy;
  logic [LVL_W-1:0]    vol_cur;

  int errors = 0;
  int checks = 0;

  pwm_volume_ramp #(
    .CH(CH),
    .OUT_W(OUT_W),
    .RAMP_DIV(RAMP_DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .vol_target(vol_target),
    .vol_load  (vol_load),
    .pwm_in    (pwm_in),
`ifdef PWM_VOL_MUTE_EN
    .mute      (mute),
`endif
    .audio_lo  (audio_lo),
    .audio_hi  (audio_hi),
    .ramp_busy (ramp_busy),
    .vol_cur   (vol_cur)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_level(input logic [LVL_W-1:0] v);
    vol_target = v;
    vol_load = 1'b1;
    tick();
    vol_load = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n;
    n = 0;
    while (ramp_busy !== 1'b0 && n < max) begin
      tick();
      n++;
    end
    check(tag, {31'd0, ramp_busy}, 32'd0);
  endtask

  task automatic wait_cur(input string tag, input logic [LVL_W-1:0] v, input int max);
    int n;
    n = 0;
    while (vol_cur !== v && n < max) begin
      tick();
      n++;
    end
    check(tag, {28'd0, vol_cur}, {28'd0, v});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    vol_target = '0;
    vol_load = 1'b0;
    pwm_in = '0;
`ifdef PWM_VOL_MUTE_EN
    mute = 1'b0;
`endif
    tick();
    tick();
    check("rst_lo", audio_lo, 32'h0);
    check("rst_hi", audio_hi, 32'h0);
    check("rst_busy", {31'd0, ramp_busy}, 32'd0);
    check("rst_cur", {28'd0, vol_cur}, 32'd0);
    rst = 1'b0;

    // Ramp 0 -> 5: one step every 4 clocks, busy falls with the last step
    vol_target = 4'd5;
    vol_load = 1'b1;
    tick();
    vol_load = 1'b0;
    check("load_edge_busy", {31'd0, ramp_busy}, 32'd0);
    tick();
    check("ramp_start_busy", {31'd0, ramp_busy}, 32'd1);
    for (int s = 1; s <= 5; s++) begin
      repeat (3) tick();
      check($sformatf("hold_%0d", s - 1), {28'd0, vol_cur}, s - 1);
      tick();
      check($sformatf("step_%0d", s), {28'd0, vol_cur}, s);
    end
    check("ramp5_done_busy", {31'd0, ramp_busy}, 32'd0);

    // Level 5 with ch0 active: 6 low bits
    pwm_in = 2'b01;
    tick();
    tick();
    check("lvl5_lo", audio_lo, 32'h003F);
    check("lvl5_hi", audio_hi, 32'h0000);

    // Level 11 and pwm_in latency
    load_level(4'd11);
    wait_idle("ramp11_timeout", 200);
    check("cur11", {28'd0, vol_cur}, 32'd11);
    tick();
    tick();
    check("lvl11_lo", audio_lo, 32'h00FF);
    check("lvl11_hi", audio_hi, 32'h000F);
    pwm_in = 2'b10;
    tick();
    check("lat1_lo", audio_lo, 32'h00FF);
    check("lat1_hi", audio_hi, 32'h000F);
    tick();
    check("lat2_lo", audio_lo, 32'hFF00);
    check("lat2_hi", audio_hi, 32'h0F00);
    pwm_in = 2'b11;
    tick();
    tick();
    check("both_lo", audio_lo, 32'hFFFF);
    check("both_hi", audio_hi, 32'h0F0F);

    // Retarget 15 -> 3 mid-ramp at cur=6 without restarting div
    load_level(4'd0);
    wait_idle("ramp0_timeout", 200);
    load_level(4'd15);
    wait_cur("reach6", 4'd6, 200);
    tick();
    vol_target = 4'd3;
    vol_load = 1'b1;
    tick();
    vol_load = 1'b0;
    check("retgt_hold_a", {28'd0, vol_cur}, 32'd6);
    tick();
    check("retgt_hold_b", {28'd0, vol_cur}, 32'd6);
    tick();
    check("retgt_step5", {28'd0, vol_cur}, 32'd5);
    check("retgt_busy", {31'd0, ramp_busy}, 32'd1);
    repeat (3) tick();
    check("retgt_hold5", {28'd0, vol_cur}, 32'd5);
    tick();
    check("retgt_step4", {28'd0, vol_cur}, 32'd4);
    repeat (4) tick();
    check("retgt_step3", {28'd0, vol_cur}, 32'd3);
    check("retgt_idle", {31'd0, ramp_busy}, 32'd0);
    tick();
    check("lvl_lat_lo", audio_lo, 32'h1F1F);
    tick();
    check("lvl3_lo", audio_lo, 32'h0F0F);
    check("lvl3_hi", audio_hi, 32'h0000);

    // Full scale, then reload of the current level
    load_level(4'd15);
    wait_idle("ramp15_timeout", 200);
    check("cur15", {28'd0, vol_cur}, 32'd15);
    tick();
    tick();
    check("lvl15_lo", audio_lo, 32'hFFFF);
    check("lvl15_hi", audio_hi, 32'hFFFF);
    load_level(4'd15);
    check("same_busy_a", {31'd0, ramp_busy}, 32'd0);
    repeat (6) tick();
    check("same_busy_b", {31'd0, ramp_busy}, 32'd0);
    check("same_cur", {28'd0, vol_cur}, 32'd15);
    check("same_lo", audio_lo, 32'hFFFF);
    check("same_hi", audio_hi, 32'hFFFF);

`ifdef PWM_VOL_MUTE_EN
    // Mute ramps to 0 and back to the kept target
    load_level(4'd10);
    wait_idle("ramp10_timeout", 200);
    check("cur10", {28'd0, vol_cur}, 32'd10);
    mute = 1'b1;
    tick();
    tick();
    check("mute_busy", {31'd0, ramp_busy}, 32'd1);
    wait_idle("mute_timeout", 200);
    check("mute_cur0", {28'd0, vol_cur}, 32'd0);
    mute = 1'b0;
    tick();
    tick();
    wait_idle("unmute_timeout", 200);
    check("unmute_cur10", {28'd0, vol_cur}, 32'd10);
`endif

    // Reset mid-ramp at cur=9; load during reset is ignored
    load_level(4'd0);
    wait_cur("reach9", 4'd9, 200);
    rst = 1'b1;
    vol_target = 4'd7;
    vol_load = 1'b1;
    tick();
    rst = 1'b0;
    vol_load = 1'b0;
    check("midrst_lo", audio_lo, 32'h0);
    check("midrst_hi", audio_hi, 32'h0);
    check("midrst_cur", {28'd0, vol_cur}, 32'd0);
    check("midrst_busy", {31'd0, ramp_busy}, 32'd0);
    repeat (3) tick();
    check("postrst_busy", {31'd0, ramp_busy}, 32'd0);
    check("postrst_cur", {28'd0, vol_cur}, 32'd0);
    check("postrst_lo", audio_lo, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_volume_ramp.md
PWM_VOLUME_RAMP -- requirements
Module: pwm_volume_ramp

Interface
REQ-001 Parameter CH, default 2, number of independent PWM channels sharing one volume.
REQ-002 Parameter OUT_W, default 8, width of each low/high audio output word; power of two, at least 2.
REQ-003 Parameter RAMP_DIV, default 256, clocks per one-level volume step; at least 1.
REQ-004 Derived constant LVL_W = clog2(2*OUT_W), the width of volume levels; default value 4.
REQ-005 clk  input  1  system clock; all logic on its rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 vol_target  input  LVL_W  requested volume level, range 0..2*OUT_W-1.
REQ-008 vol_load  input  1  one-cycle strobe that captures vol_target.
REQ-009 pwm_in  input  CH  1-bit PWM stream per channel.
REQ-010 audio_lo  output  CH*OUT_W  low-range drive; channel k occupies bits [k*OUT_W +: OUT_W].
REQ-011 audio_hi  output  CH*OUT_W  high-range drive; same channel packing as audio_lo.
REQ-012 ramp_busy  output  1  high while the current level differs from the target level.
REQ-013 vol_cur  output  LVL_W  currently applied volume level.

Function
REQ-014 Registers: tgt (target level), cur (current level), div counter, and a 2-state FSM (IDLE, RAMP).
REQ-015 A vol_load pulse SHALL latch vol_target into tgt on the same edge; when OUT_W is a power of two, every code is in range and no clamp is needed.
REQ-016 IDLE: on the edge where tgt != cur, go to RAMP and clear div.
REQ-017 RAMP: div counts 0..RAMP_DIV-1; on wrap, cur steps one level toward tgt; if the step makes cur == tgt, go to IDLE.
REQ-018 A new vol_load during RAMP SHALL retarget without restarting div; direction is re-evaluated from cur at the next step; a target equal to cur ends the ramp at the next div wrap without stepping.
REQ-019 ramp_busy = (state == RAMP), registered.
REQ-020 Level map, per channel with fill count n: level 0 gives lo = hi = 0; level 1..OUT_W-1 gives lo = L+1 low bits of pwm_in[k] replicated and hi = 0; level OUT_W gives lo = all bits of pwm_in[k] and hi = 0; level OUT_W+j (j >= 1) gives lo = all bits and hi = j+1 low bits replicated.
REQ-021 Mapping pipeline: stage 1 registers the mapped words; stage 2 registers the outputs. Latency from pwm_in (or cur) to audio_lo/hi is exactly 2 clocks.
REQ-022 cur SHALL never leave range 0..2*OUT_W-1 and SHALL change by at most 1 per RAMP_DIV clocks.

Reset
REQ-023 When rst is high at a clock edge: tgt=0, cur=0, div=0, state=IDLE, both pipeline stages=0, audio_lo=audio_hi=0, ramp_busy=0, vol_cur=0.
REQ-024 rst asserted mid-ramp SHALL abort the ramp immediately with no step; vol_load during rst is ignored.

Configuration
REQ-025 Macro PWM_VOL_MUTE_EN, when defined, adds input mute (1 bit): while mute=1 the effective target is 0 (ramp down at normal rate); tgt is kept and the ramp resumes toward it when mute=0.
REQ-026 Without PWM_VOL_MUTE_EN: no mute port; the effective target is always tgt.

Structure
REQ-027 Package pwm_audio_pkg SHALL hold the FSM state enum (IDLE, RAMP), the LVL_W computation function, and a level-to-fill-count function.
REQ-028 One sub-module, pwm_level_mapper (combinational; level plus 1-bit input to lo/hi words), is instantiated once per channel via generate.

Verification (CH=2, OUT_W=8, RAMP_DIV=4)
REQ-029 Reset, then vol_load with target 5 -> cur steps 0→1→…→5, one step every 4 clocks; ramp_busy drops on the edge where cur reaches 5.
REQ-030 Hold cur=11 with pwm_in=2'b01 -> ch0 lo=8'hFF, hi=8'h0F; ch1 lo=0, hi=0; output changes appear 2 clocks after a pwm_in change.
REQ-031 Ramp 0→15 in progress, load 3 when cur=6 -> cur steps 6→5→4→3, div is not restarted, then IDLE.
REQ-032 Assert rst for 1 clock during a ramp at cur=9 -> next cycle all outputs are 0, cur=0, ramp_busy=0.
REQ-033 With PWM_VOL_MUTE_EN: cur=10, assert mute -> ramp to 0; deassert mute -> ramp back to 10 with tgt unchanged.
REQ-034 Load target equal to cur -> ramp_busy stays 0 and outputs are unchanged.
